// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner.
// Time-multiplexes NUM_DIGITS digits onto one shared cathode bus. Each digit
// slot starts with a short dead time so ghosting between digits is avoided.
// New values are double-buffered: a load goes to a staging register and is
// promoted to the display shadow only at a frame boundary, so a frame never
// shows a mix of two loads.
// The design also provides leading-zero blanking, per-digit blinking, and
// optional hex glyphs.

module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int DEADTIME     = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_CNT   = PW'(DEADTIME);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'b1111111;
    localparam logic          HEX_ON     = (HEX_MODE != 0);

    // Active-low glyph table {g,f,e,d,c,b,a}; hex letters only when enabled.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = HEX_ON ? 7'b0001000 : SEG_BLANK;
            4'hB:    pat = HEX_ON ? 7'b0000011 : SEG_BLANK;
            4'hC:    pat = HEX_ON ? 7'b1000110 : SEG_BLANK;
            4'hD:    pat = HEX_ON ? 7'b0100001 : SEG_BLANK;
            4'hE:    pat = HEX_ON ? 7'b0000110 : SEG_BLANK;
            4'hF:    pat = HEX_ON ? 7'b0001110 : SEG_BLANK;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Scan timing state
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          frame_done_q;
    logic          tc_s;
    logic          wrap_s;

    // Load path: staging buffer and display shadow
    logic [4*NUM_DIGITS-1:0] stage_dig_q, shadow_dig_q;
    logic [NUM_DIGITS-1:0]   stage_dp_q, shadow_dp_q;
    logic [NUM_DIGITS-1:0]   stage_mask_q, shadow_mask_q;
    logic                    pend_q;

    // Blink state
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;

    // Output stage
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    // Digit decode helpers
    logic [3:0]            dig_arr_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank_s;
    logic [3:0]            cur_code_s;
    logic                  blank_s;

    assign tc_s   = (presc_q == PRESC_LAST);
    assign wrap_s = tc_s && (idx_q == IDX_LAST);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign dig_arr_s[k] = shadow_dig_q[4*k +: 4];
    end

    // Digit 0 always shows; higher digits blank while they and all above are zero.
    assign lz_blank_s[0] = 1'b0;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
        assign lz_blank_s[k] = lz_en & ~(|shadow_dig_q[4*NUM_DIGITS-1:4*k]);
    end

    // Next prescaler and scan index.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (tc_s) begin
            presc_d = {PW{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IW{1'b0}};
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Prescaler, scan index and frame wrap pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= {PW{1'b0}};
            idx_q        <= {IW{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_done_q <= wrap_s;
        end
    end

    // Double-buffered load: stage on strobe, promote to shadow only at frame wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_dig_q   <= {(4*NUM_DIGITS){1'b0}};
            stage_dp_q    <= {NUM_DIGITS{1'b0}};
            stage_mask_q  <= {NUM_DIGITS{1'b0}};
            shadow_dig_q  <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_q   <= {NUM_DIGITS{1'b0}};
            shadow_mask_q <= {NUM_DIGITS{1'b0}};
            pend_q        <= 1'b0;
        end else begin
            if (load) begin
                stage_dig_q  <= digits_in;
                stage_dp_q   <= dp_in;
                stage_mask_q <= blink_mask;
            end
            if (wrap_s) begin
                pend_q <= 1'b0;
                if (load) begin
                    shadow_dig_q  <= digits_in;
                    shadow_dp_q   <= dp_in;
                    shadow_mask_q <= blink_mask;
                end else if (pend_q) begin
                    shadow_dig_q  <= stage_dig_q;
                    shadow_dp_q   <= stage_dp_q;
                    shadow_mask_q <= stage_mask_q;
                end
            end else if (load) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Frame counter for blinking; phase flips every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= {BW{1'b0}};
            blink_phase_q <= 1'b1;
        end else if (wrap_s) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= {BW{1'b0}};
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    // Pin values for the current slot, computed from the current scan state.
    always_comb begin
        cur_code_s = dig_arr_s[idx_q];
        blank_s    = lz_blank_s[idx_q] | (shadow_mask_q[idx_q] & ~blink_phase_q);
        if (blank_s) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(cur_code_s);
        end
        dp_d = ~shadow_dp_q[idx_q];
        an_d = {NUM_DIGITS{1'b1}};
        if (presc_q < DEAD_CNT) begin
            an_d = {NUM_DIGITS{1'b1}};
        end else begin
            an_d[idx_q] = 1'b0;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4 digits, 4 clocks per slot,
// 1 dead cycle, blink every 2 frames. Two instances differ only in HEX_MODE.

module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int checks = 0;
    int failures = 0;

    // Frame capture: index j is the j-th sample after a frame_done sample.
    logic [3:0]  cap_an  [16];
    logic [6:0]  cap_seg [16];
    logic [6:0]  cap_segh[16];
    logic        cap_dp  [16];
    logic        cap_fd  [16];

    seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEADTIME(1),
                        .BLINK_FRAMES(2), .HEX_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .lz_en(lz_en), .load(load),
        .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));

    seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEADTIME(1),
                        .BLINK_FRAMES(2), .HEX_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .lz_en(lz_en), .load(load),
        .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            4'hF: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int j);
        logic [3:0] one;
        one = 4'b0001;
        if ((j % 4) == 0) return 4'b1111;
        else return ~(one << (j / 4));
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
        digits_in = d; dp_in = p; blink_mask = m; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (fd0 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL wait_frame got=no_frame_done exp=frame_done within 64 cycles");
        end
    endtask

    task automatic capture_frame();
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            cap_an[j] = an0; cap_seg[j] = seg0; cap_segh[j] = seg1;
            cap_dp[j] = dp0; cap_fd[j] = fd0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({an0, seg0, dp0, fd0} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_pins got=%b_%b_%b_%b exp=1111_1111111_1_0", an0, seg0, dp0, fd0);
        end
        checks++;
        if ({an1, seg1, dp1, fd1} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_pins_hex got=%b_%b_%b_%b exp=1111_1111111_1_0", an1, seg1, dp1, fd1);
        end
    endtask

    task automatic test_scan();
        logic [6:0] e;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (an0 !== 4'b1111) begin
            failures++;
            $display("FAIL release_dead got=%b exp=1111", an0);
        end
        @(negedge clk);
        checks++;
        if (an0 !== 4'b1110 || seg0 !== 7'b1000000) begin
            failures++;
            $display("FAIL release_first_lit got=%b/%b exp=1110/1000000", an0, seg0);
        end
        do_load(16'h4321, 4'b0000, 4'b0000);
        wait_frame();
        capture_frame();
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (cap_an[j] !== exp_an(j)) begin
                failures++;
                $display("FAIL scan_an j=%0d got=%b exp=%b", j, cap_an[j], exp_an(j));
            end
            checks++;
            if (cap_fd[j] !== (j == 15)) begin
                failures++;
                $display("FAIL scan_frame_done j=%0d got=%b exp=%b", j, cap_fd[j], (j == 15));
            end
            if ((j % 4) != 0) begin
                e = seg_of(4'(j / 4 + 1));
                checks++;
                if (cap_seg[j] !== e || cap_segh[j] !== e || cap_dp[j] !== 1'b1) begin
                    failures++;
                    $display("FAIL scan_seg j=%0d got=%b/%b/%b exp=%b/%b/1", j, cap_seg[j], cap_segh[j], cap_dp[j], e, e);
                end
            end
        end
    endtask

    task automatic test_tearfree();
        logic [6:0] e;
        wait_frame();
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if ((j % 4) != 0) begin
                e = seg_of(4'(j / 4 + 1));
                checks++;
                if (seg0 !== e) begin
                    failures++;
                    $display("FAIL tear_old j=%0d got=%b exp=%b", j, seg0, e);
                end
            end
            if (j == 15) begin
                checks++;
                if (fd0 !== 1'b1) begin
                    failures++;
                    $display("FAIL tear_wrap got=%b exp=1", fd0);
                end
            end
            if (j == 6) begin
                digits_in = 16'h9999; load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        capture_frame();
        for (int j = 1; j < 16; j += 4) begin
            for (int t = 0; t < 3; t++) begin
                checks++;
                if (cap_seg[j + t] !== 7'b0010000) begin
                    failures++;
                    $display("FAIL tear_new j=%0d got=%b exp=0010000", j + t, cap_seg[j + t]);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] e [4];
        logic [15:0] vec [3];
        logic [3:0]  dpv;
        lz_en = 1'b1;
        vec[0] = 16'h0007; vec[1] = 16'h0000; vec[2] = 16'h0700;
        dpv = 4'b0100;
        for (int v = 0; v < 3; v++) begin
            if (v == 0) begin
                e[0] = 7'b1111000; e[1] = 7'b1111111; e[2] = 7'b1111111; e[3] = 7'b1111111;
            end else if (v == 1) begin
                e[0] = 7'b1000000; e[1] = 7'b1111111; e[2] = 7'b1111111; e[3] = 7'b1111111;
            end else begin
                e[0] = 7'b1000000; e[1] = 7'b1000000; e[2] = 7'b1111000; e[3] = 7'b1111111;
            end
            do_load(vec[v], dpv, 4'b0000);
            wait_frame();
            capture_frame();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[4*k + 2] !== e[k]) begin
                    failures++;
                    $display("FAIL lz_seg v=%0d slot=%0d got=%b exp=%b", v, k, cap_seg[4*k + 2], e[k]);
                end
                checks++;
                if (cap_dp[4*k + 2] !== ~dpv[k]) begin
                    failures++;
                    $display("FAIL lz_dp v=%0d slot=%0d got=%b exp=%b", v, k, cap_dp[4*k + 2], ~dpv[k]);
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_hex();
        logic [6:0] eh [4];
        eh[0] = 7'b0001000; eh[1] = 7'b0000011; eh[2] = 7'b1000110; eh[3] = 7'b0001110;
        do_load(16'hFCBA, 4'b0000, 4'b0000);
        wait_frame();
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_seg[4*k + 3] !== 7'b1111111) begin
                failures++;
                $display("FAIL hex_off slot=%0d got=%b exp=1111111", k, cap_seg[4*k + 3]);
            end
            checks++;
            if (cap_segh[4*k + 3] !== eh[k]) begin
                failures++;
                $display("FAIL hex_on slot=%0d got=%b exp=%b", k, cap_segh[4*k + 3], eh[k]);
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] e;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_load(16'h4321, 4'b0000, 4'b0001);
        wait_frame();
        for (int f = 1; f <= 6; f++) begin
            capture_frame();
            e = (((f / 2) % 2) == 0) ? 7'b1111001 : 7'b1111111;
            for (int j = 1; j < 4; j++) begin
                checks++;
                if (cap_seg[j] !== e) begin
                    failures++;
                    $display("FAIL blink_d0 frame=%0d j=%0d got=%b exp=%b", f, j, cap_seg[j], e);
                end
            end
            checks++;
            if (cap_seg[5] !== 7'b0100100) begin
                failures++;
                $display("FAIL blink_d1 frame=%0d got=%b exp=0100100", f, cap_seg[5]);
            end
        end
    endtask

    task automatic test_reset_pending();
        wait_frame();
        repeat (5) @(negedge clk);
        do_load(16'h8888, 4'b1111, 4'b0000);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({an0, seg0, dp0, fd0} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_async got=%b_%b_%b_%b exp=1111_1111111_1_0", an0, seg0, dp0, fd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_frame();
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_seg[4*k + 1] !== 7'b1000000 || cap_dp[4*k + 1] !== 1'b1) begin
                failures++;
                $display("FAIL rst_discard slot=%0d got=%b/%b exp=1000000/1", k, cap_seg[4*k + 1], cap_dp[4*k + 1]);
            end
            checks++;
            if (cap_an[4*k + 1] !== exp_an(4*k + 1)) begin
                failures++;
                $display("FAIL rst_an slot=%0d got=%b exp=%b", k, cap_an[4*k + 1], exp_an(4*k + 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearfree();
        test_leading_zero();
        test_hex();
        test_blink();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
